// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared types and constants for the MAC dot-product sequencer
// Contents: sequencer state enum, default widths, MAC pipeline flush depth.
package mac_seq_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 32;
    localparam int DEF_LEN_WIDTH  = 10;

    // Zero-operand cycles needed to drain the MAC product register into the accumulator.
    localparam int MAC_FLUSH_CYCLES = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_FLUSH,
        S_CAPTURE,
        S_OUT
    } seq_state_t;

endpackage

// File: rtl/mac_seq_addr_counter.sv
// rtl/mac_seq_addr_counter.sv - loadable element down-counter with buffer address up-counter
// Ports:
//   clk, rst   clock, async active-high reset
//   load, len  load remaining-element count and clear address
//   step       consume one element (count down, address up)
//   addr       current buffer address
//   last       high while exactly one element remains
module mac_seq_addr_counter #(
    parameter int LEN_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 step,
    output logic [LEN_WIDTH-1:0] addr,
    output logic                 last
);

    logic [LEN_WIDTH-1:0] remaining;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            addr      <= '0;
        end else if (load) begin
            remaining <= len;
            addr      <= '0;
        end else if (step) begin
            remaining <= remaining - LEN_WIDTH'(1);
            addr      <= addr + LEN_WIDTH'(1);
        end
    end

    assign last = (remaining == LEN_WIDTH'(1));

endmodule

// File: rtl/mac_dot_sequencer.sv
// rtl/mac_dot_sequencer.sv - operand-issue controller driving one INT8 MAC for a dot-product job
// Ports:
//   clk, rst                       clock, async active-high reset
//   start, start_ready, len        job request handshake and element count
//   act_addr, wgt_addr, buf_rd_en  buffer reads (data returns next cycle)
//   act_rdata, wgt_rdata           signed buffer data
//   mac_a, mac_b, mac_enable, mac_accumulate, mac_result   MAC interface
//   res_valid, res_ready, res_data result handshake
//   busy                           high whenever not idle
// Option macro SEQ_RELU_EN: clamp the captured result to max(result, 0).
module mac_dot_sequencer
    import mac_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  start_ready,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic [LEN_WIDTH-1:0]  act_addr,
    output logic [LEN_WIDTH-1:0]  wgt_addr,
    output logic                  buf_rd_en,
    input  logic [DATA_WIDTH-1:0] act_rdata,
    input  logic [DATA_WIDTH-1:0] wgt_rdata,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    output logic                  mac_enable,
    output logic                  mac_accumulate,
    input  logic [ACC_WIDTH-1:0]  mac_result,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data,
    output logic                  busy
);

    seq_state_t state, next_state;

    logic [LEN_WIDTH-1:0] addr;
    logic                 last;
    logic                 accept;
    logic [1:0]           flush_cnt;
    logic                 rd_d;      // buffer data is on the read bus this cycle
    logic                 first_d1;  // element 0 is on the MAC bus this cycle
    logic                 first_d2;  // element 0's product is being loaded this cycle
    logic [ACC_WIDTH-1:0] capture_value;

    assign accept = start && (state == S_IDLE);

    mac_seq_addr_counter #(
        .LEN_WIDTH(LEN_WIDTH)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .len  (len),
        .step (state == S_READ),
        .addr (addr),
        .last (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (start) next_state = (len == '0) ? S_OUT : S_READ;
            S_READ:    if (last) next_state = S_FLUSH;
            // First FLUSH cycle still carries the last element; the rest are zero operands.
            S_FLUSH:   if (flush_cnt == 2'(MAC_FLUSH_CYCLES)) next_state = S_CAPTURE;
            S_CAPTURE: next_state = S_OUT;
            S_OUT:     if (res_ready) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= '0;
            rd_d      <= 1'b0;
            first_d1  <= 1'b0;
            first_d2  <= 1'b0;
        end else begin
            flush_cnt <= (state == S_FLUSH) ? flush_cnt + 2'd1 : 2'd0;
            rd_d      <= buf_rd_en;
            first_d1  <= buf_rd_en && (addr == '0);
            first_d2  <= first_d1;
        end
    end

`ifdef SEQ_RELU_EN
    assign capture_value = mac_result[ACC_WIDTH-1] ? '0 : mac_result;
`else
    assign capture_value = mac_result;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data <= '0;
        end else if (accept && (len == '0)) begin
            res_data <= '0;
        end else if (state == S_CAPTURE) begin
            res_data <= capture_value;
        end
    end

    assign start_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign res_valid   = (state == S_OUT);
    assign buf_rd_en   = (state == S_READ);
    assign act_addr    = buf_rd_en ? addr : '0;
    assign wgt_addr    = buf_rd_en ? addr : '0;

    // Operands come straight from the buffers while read data is valid; zero otherwise (flush).
    assign mac_a      = rd_d ? act_rdata : '0;
    assign mac_b      = rd_d ? wgt_rdata : '0;
    assign mac_enable = rd_d || (state == S_FLUSH);
    // The MAC reloads (accumulate=0) when element 0's product reaches the accumulator.
    assign mac_accumulate = mac_enable && !first_d2;

endmodule

// File: doc/mac_dot_sequencer.md
# mac_dot_sequencer

Operand-issue controller for the INT8 MAC datapath. It accepts a dot-product job (length N), reads paired activation/weight bytes from two synchronous buffers, and drives the MAC operand/enable/accumulate inputs with correct pipeline alignment. It flushes the MAC pipeline, captures the final accumulator value, and returns it on a valid/ready result port. It sits between the layer controller (job issue) and one MAC unit.

## Interface
- DATA_WIDTH, 8: operand width (signed).
- ACC_WIDTH, 32: MAC accumulator / result width.
- LEN_WIDTH, 10: job length width; also buffer address width.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request; accepted when start && start_ready.
- start_ready  out  1  high only in IDLE.
- len  in  LEN_WIDTH  element count N, sampled on accept.
- act_addr / wgt_addr  out  LEN_WIDTH  buffer read address.
- buf_rd_en  out  1  read strobe to both buffers; data returns next cycle.
- act_rdata / wgt_rdata  in  DATA_WIDTH  signed read data.
- mac_a / mac_b  out  DATA_WIDTH  MAC operands.
- mac_enable  out  1  MAC advance strobe.
- mac_accumulate  out  1  MAC accumulate select.
- mac_result  in  ACC_WIDTH  MAC result register.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  ACC_WIDTH  dot product.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, READ, FLUSH, CAPTURE, OUT.
- IDLE: start_ready=1. On accept, latch N. If N=0, go to OUT with res_data=0 and issue nothing. Otherwise, go to READ.
- READ: N cycles with buf_rd_en=1 and addresses 0..N-1, incrementing by 1. There is no wrap; the max address is N-1.
- mac_a/mac_b are driven by act_rdata/wgt_rdata on the cycle after each read. mac_enable is buf_rd_en delayed by 1 cycle.
- MAC contract: mac_accumulate applies to the product of the pair issued on the previous enabled cycle.
  - mac_accumulate=0 on the enabled cycle immediately after element 0's cycle; 1 on all other enabled cycles.
  - For N=1, the 0 falls on the first zero-flush cycle.
- FLUSH: covers the last data cycle plus 2 cycles with mac_a=mac_b=0, mac_enable=1, mac_accumulate=1 (except the N=1 case above).
- CAPTURE: mac_enable=0. res_data <= mac_result at cycle end.
- OUT: res_valid=1, res_data stable until res_ready. Return to IDLE on res_valid && res_ready.
- start in any non-IDLE state is ignored (start_ready=0).
- Arithmetic: the sum is carried by the MAC in ACC_WIDTH two's complement and wraps on overflow. The sequencer does no arithmetic except in the optional stage below.
- Reset (async, any state): state=IDLE, counters=0, res_data=0. All outputs 0 except start_ready=1. An aborted job produces no result. The MAC is left for its own reset/next job; the next job's accumulate=0 reloads it.

## Timing
- Accept at cycle t. Reads occur in t+1..t+N. Element k is on the MAC bus at t+2+k. Zero-flush cycles are t+N+2 and t+N+3.
- mac_result is final during t+N+4 (CAPTURE). res_valid rises at t+N+5, so latency is N+5 cycles for N≥1.
- N=0: res_valid at t+1.
- Back-to-back: if res_ready is high in the first OUT cycle, start_ready is high on the next cycle. The minimum job period is N+6 cycles.
- mac_enable is never high outside t+2..t+N+3.

## Configuration
- SEQ_RELU_EN: when defined, CAPTURE stores max(mac_result, 0) as a signed compare. When undefined, it stores mac_result unchanged. Timing is identical either way.

## Structure
- Shared package mac_seq_pkg holds:
  - the state enum;
  - the default DATA_WIDTH/ACC_WIDTH/LEN_WIDTH;
  - the constant MAC_FLUSH_CYCLES=2.
- One natural sub-module: mac_seq_addr_counter. It is a loadable down-counter plus address up-counter and asserts the last-element flag.

## Test plan
- N=4, act=[1,2,3,4], wgt=[5,6,7,8] (use a behavioural MAC model) -> res_data=70, res_valid at t+9, exactly 6 mac_enable cycles.
- N=2, act=[-128,-128], wgt=[-128,127] -> res_data=16384-16256=128. Check mac_accumulate=0 only at t+3.
- N=0 -> res_valid at t+1, res_data=0, no buf_rd_en or mac_enable.
- N=3 all 2×3, res_ready held low 5 cycles -> res_data=18 stable, start_ready low throughout. A second start in that window is ignored.
- rst asserted at t+3 of N=8 job -> all outputs zero immediately. A new N=1 job (3×-4) then gives -12.
- Dot product -10 (N=1, act=-2, wgt=5) -> 0 with SEQ_RELU_EN, -10 without.
